// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and the baud divisor mapping,
// so transmitter and receiver derive identical bit periods from CLK_FREQ.
package uart_pkg;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_38400  = 38400;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_t;

  // Unused selector codes fall back to the slowest rate.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [2:0] sel);
    int unsigned rate;
    case (sel)
      3'd1:    rate = BAUD_19200;
      3'd2:    rate = BAUD_38400;
      3'd3:    rate = BAUD_57600;
      3'd4:    rate = BAUD_115200;
      default: rate = BAUD_9600;
    endcase
    return clk_freq / rate;
  endfunction

  function automatic int unsigned div_width(input int unsigned clk_freq);
    return $clog2(clk_freq / BAUD_9600 + 1);
  endfunction

endpackage

// File: rtl/uart_tx_baud_if.sv
// Byte handshake, baud selection and serial line status of the UART transmitter.
interface uart_tx_baud_if;
  logic [2:0] baud_sel;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output baud_sel, tx_data, tx_valid,
    input  tx_ready, txd, tx_busy, tx_done
  );

  modport slave (
    input  baud_sel, tx_data, tx_valid,
    output tx_ready, txd, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Maps baud_sel to a bit-period divisor and times bit periods with the latched divisor.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DIV_W    = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       baud_sel,
  output logic [DIV_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  output logic             bit_tick
);

  logic [DIV_W-1:0] timer_q, timer_d;

  assign div_sel = DIV_W'(baud_div(CLK_FREQ, baud_sel));

  // Timer sits at zero while idle so the first bit of a frame is full length.
  always_comb begin
    timer_d  = '0;
    bit_tick = 1'b0;
    if (run) begin
      if (timer_q == div - DIV_W'(1)) begin
        bit_tick = 1'b1;
      end else begin
        timer_d = timer_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

endmodule

// File: rtl/uart_tx_baud.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits,
// with the bit rate chosen per byte from baud_sel.
module uart_tx_baud
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned STOP_BITS  = 2,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  uart_tx_baud_if.slave bus
);

  localparam int unsigned DIV_W = div_width(CLK_FREQ);

  tx_state_t        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic             parity_q, parity_d;
  logic             txd_q, txd_d;
  logic [DIV_W-1:0] div_sel;
  logic             bit_tick;
  logic             accept;
  logic             done;

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .DIV_W    (DIV_W)
  ) u_baud_gen (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .baud_sel (bus.baud_sel),
    .div_sel  (div_sel),
    .div      (div_q),
    .run      (state_q != IDLE),
    .bit_tick (bit_tick)
  );

  assign accept = bus.tx_valid && (state_q == IDLE);

  // txd_d is the line level for the cycle after the edge, keeping txd glitch-free.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    txd_d      = txd_q;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          shift_d    = bus.tx_data;
          div_d      = div_sel;
          parity_d   = (^bus.tx_data) ^ (PARITY_ODD != 0);
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          state_d    = START;
          txd_d      = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txd_d   = parity_q;
            end else begin
              state_d    = STOP;
              stop_idx_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (bit_tick) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
    end
  end

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.tx_busy  = (state_q != IDLE);
  assign bus.txd      = txd_q;
  assign bus.tx_done  = done;

endmodule

// File: tb/tb_uart_tx_baud.sv
// Drives four transmitter configurations through one shared stimulus port and
// compares every serial line cycle against a bit-list model of the expected frame.
module tb_uart_tx_baud;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data_m  = 8'h00;
  logic [2:0] baud_sel_m = 3'd0;
  logic       tx_valid_m = 1'b0;
  int         sel = 0;
  logic       txd_m, ready_m, busy_m, done_m;
  int         checks = 0;
  int         failures = 0;
  int unsigned rate [5] = '{9600, 19200, 38400, 57600, 115200};

  always #5 clk = ~clk;

  uart_tx_baud_if if_a ();
  uart_tx_baud_if if_s ();
  uart_tx_baud_if if_pe ();
  uart_tx_baud_if if_po ();

  assign if_a.tx_data   = tx_data_m;
  assign if_a.baud_sel  = baud_sel_m;
  assign if_a.tx_valid  = tx_valid_m && (sel == 0);
  assign if_s.tx_data   = tx_data_m;
  assign if_s.baud_sel  = baud_sel_m;
  assign if_s.tx_valid  = tx_valid_m && (sel == 1);
  assign if_pe.tx_data  = tx_data_m;
  assign if_pe.baud_sel = baud_sel_m;
  assign if_pe.tx_valid = tx_valid_m && (sel == 2);
  assign if_po.tx_data  = tx_data_m;
  assign if_po.baud_sel = baud_sel_m;
  assign if_po.tx_valid = tx_valid_m && (sel == 3);

  uart_tx_baud dut_a (.sys_clk(clk), .sys_rst(rst), .bus(if_a));
  uart_tx_baud #(.CLK_FREQ(500_000)) dut_s (.sys_clk(clk), .sys_rst(rst), .bus(if_s));
  uart_tx_baud #(.CLK_FREQ(500_000), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0))
    dut_pe (.sys_clk(clk), .sys_rst(rst), .bus(if_pe));
  uart_tx_baud #(.CLK_FREQ(500_000), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1))
    dut_po (.sys_clk(clk), .sys_rst(rst), .bus(if_po));

  always_comb begin
    txd_m = if_a.txd; ready_m = if_a.tx_ready; busy_m = if_a.tx_busy; done_m = if_a.tx_done;
    case (sel)
      1: begin txd_m = if_s.txd;  ready_m = if_s.tx_ready;  busy_m = if_s.tx_busy;  done_m = if_s.tx_done;  end
      2: begin txd_m = if_pe.txd; ready_m = if_pe.tx_ready; busy_m = if_pe.tx_busy; done_m = if_pe.tx_done; end
      3: begin txd_m = if_po.txd; ready_m = if_po.tx_ready; busy_m = if_po.tx_busy; done_m = if_po.tx_done; end
      default: ;
    endcase
  end

  function automatic int unsigned expDiv(input int s, input logic [2:0] bs);
    int unsigned clk_hz;
    int idx;
    clk_hz = (s == 0) ? 50_000_000 : 500_000;
    idx = (bs > 3'd4) ? 0 : int'(bs);
    return clk_hz / rate[idx];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a byte and waits (bounded) for the handshake; returns in START cycle 0.
  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] bs, input bit hold, output bit ok);
    ok = 1'b0;
    tx_data_m  = d;
    baud_sel_m = bs;
    tx_valid_m = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (ready_m === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tx_valid_m = 1'b0;
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) tx_valid_m = 1'b0;
  endtask

  // Called in START cycle 0; returns in the idle cycle right after the frame.
  task automatic captureFrame(input logic [7:0] d, input logic [2:0] bs, input bit scramble,
                              input string tag, output int done_at);
    bit   q[$];
    logic obs [16];
    int   div, total, ones, nbad, nbusy, ndone, stops;
    div = int'(expDiv(sel, bs));
    ones = 0; nbad = 0; nbusy = 0; ndone = 0; done_at = -1;
    stops = (sel <= 1) ? 2 : 1;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (sel >= 2) q.push_back((sel == 3) ? ((ones % 2) == 0) : ((ones % 2) == 1));
    for (int i = 0; i < stops; i++) q.push_back(1'b1);
    total = q.size() * div;
    for (int k = 0; k < total; k++) begin
      if (txd_m !== q[k / div]) nbad++;
      if ((k % div) == (div / 2)) obs[k / div] = txd_m;
      if (busy_m === 1'b1) nbusy++;
      if (done_m === 1'b1) begin
        ndone++;
        done_at = k;
      end
      if (scramble && k == div / 2) begin
        tx_data_m  = 8'($urandom);
        baud_sel_m = 3'($urandom);
      end
      if (k < total - 1) @(negedge clk);
    end
    for (int i = 0; i < q.size(); i++)
      checkOutput($sformatf("%s_bit%0d", tag, i), {31'd0, obs[i]}, {31'd0, q[i]});
    checkOutput({tag, "_wave_errs"}, nbad, 0);
    checkOutput({tag, "_busy_cycles"}, nbusy, total);
    checkOutput({tag, "_done_count"}, ndone, 1);
    checkOutput({tag, "_done_at"}, done_at, total - 1);
    @(negedge clk);
    checkOutput({tag, "_idle_txd"}, {31'd0, txd_m}, 32'd1);
    checkOutput({tag, "_idle_busy"}, {31'd0, busy_m}, 32'd0);
    checkOutput({tag, "_idle_ready"}, {31'd0, ready_m}, 32'd1);
  endtask

  initial begin
    bit         ok;
    int         da, nbad, ndone, nbusy, div;
    logic [7:0] d;
    logic [2:0] bs;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checkOutput($sformatf("rst%0d_txd", s), {31'd0, txd_m}, 32'd1);
      checkOutput($sformatf("rst%0d_busy", s), {31'd0, busy_m}, 32'd0);
      checkOutput($sformatf("rst%0d_done", s), {31'd0, done_m}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checkOutput($sformatf("post_rst%0d_ready", s), {31'd0, ready_m}, 32'd1);
    end
    sel = 0;
    nbad = 0;
    for (int k = 0; k < 20; k++) begin
      if (txd_m !== 1'b1 || busy_m !== 1'b0) nbad++;
      @(negedge clk);
    end
    checkOutput("idle_hold", nbad, 0);

    $display("[TB] 0x55 at 9600, 50 MHz defaults");
    applyStimulus(8'h55, 3'd0, 1'b0, ok);
    if (ok) begin
      captureFrame(8'h55, 3'd0, 1'b1, "a55", da);
      checkOutput("a55_done_clocks", da + 1, 32'd57288);
    end

    $display("[TB] back-to-back 0xB7, 0x89 at 115200");
    applyStimulus(8'hB7, 3'd4, 1'b1, ok);
    if (ok) begin
      tx_data_m = 8'h89;
      captureFrame(8'hB7, 3'd4, 1'b0, "b2b1", da);
      @(negedge clk);
      checkOutput("b2b_gap_busy", {31'd0, busy_m}, 32'd1);
      checkOutput("b2b_gap_txd", {31'd0, txd_m}, 32'd0);
      tx_valid_m = 1'b0;
      captureFrame(8'h89, 3'd4, 1'b0, "b2b2", da);
      checkOutput("b2b2_done_clocks", da + 1, 32'd4774);
    end

    sel = 1;
    $display("[TB] 0xA3 then 0x89 at different rates");
    applyStimulus(8'hA3, 3'd1, 1'b0, ok);
    if (ok) captureFrame(8'hA3, 3'd1, 1'b1, "sA3", da);
    applyStimulus(8'h89, 3'd4, 1'b0, ok);
    if (ok) captureFrame(8'h89, 3'd4, 1'b1, "s89", da);

    $display("[TB] reset during D3");
    d = 8'hA5;
    applyStimulus(d, 3'd0, 1'b0, ok);
    if (ok) begin
      div = int'(expDiv(1, 3'd0));
      repeat (4 * div + div / 2) @(negedge clk);
      checkOutput("mid_d3_txd", {31'd0, txd_m}, {31'd0, d[3]});
      checkOutput("mid_d3_busy", {31'd0, busy_m}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_txd", {31'd0, txd_m}, 32'd1);
      checkOutput("mid_rst_busy", {31'd0, busy_m}, 32'd0);
      checkOutput("mid_rst_done", {31'd0, done_m}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      nbad = 0; ndone = 0; nbusy = 0;
      for (int k = 0; k < 12 * div; k++) begin
        @(negedge clk);
        if (txd_m !== 1'b1) nbad++;
        if (done_m === 1'b1) ndone++;
        if (busy_m === 1'b1) nbusy++;
      end
      checkOutput("after_rst_txd_errs", nbad, 0);
      checkOutput("after_rst_done", ndone, 0);
      checkOutput("after_rst_busy", nbusy, 0);
      applyStimulus(8'h3C, 3'd0, 1'b0, ok);
      if (ok) captureFrame(8'h3C, 3'd0, 1'b1, "clean", da);
    end

    $display("[TB] random frames");
    for (int n = 0; n < 6; n++) begin
      d  = 8'($urandom);
      bs = 3'($urandom_range(0, 7));
      applyStimulus(d, bs, 1'b0, ok);
      if (ok) captureFrame(d, bs, 1'b1, $sformatf("rnd%0d", n), da);
    end

    $display("[TB] parity configurations");
    for (int s = 2; s < 4; s++) begin
      sel = s;
      applyStimulus(8'hB7, 3'd0, 1'b0, ok);
      if (ok) begin
        captureFrame(8'hB7, 3'd0, 1'b1, $sformatf("par%0d_B7", s), da);
        checkOutput($sformatf("par%0d_frame_clocks", s), da + 1, 11 * expDiv(s, 3'd0));
      end
      for (int n = 0; n < 2; n++) begin
        d  = 8'($urandom);
        bs = 3'($urandom_range(0, 4));
        applyStimulus(d, bs, 1'b0, ok);
        if (ok) captureFrame(d, bs, 1'b1, $sformatf("par%0d_rnd%0d", s, n), da);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
